spi_slave_sync: RTL

//  Parametrised SPI slave that oversamples SCLK/MOSI/CE0 in the system clk domain.

---
 rtl/spi_slave_sync.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/spi_slave_sync.sv
// rtl/spi_slave_sync.sv - SPI slave oversampled in the clk domain, all CPOL/CPHA modes
// Multi-word frames, one-entry TX holding buffer and RX completion strobe.
module spi_slave_sync #(
    parameter int          WIDTH       = 8,
    parameter int          CPOL        = 0,
    parameter int          CPHA        = 0,
    parameter int          MSB_FIRST   = 1,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] TX_DEFAULT  = 32'h0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SCLK,
    input  logic             MOSI,
    input  logic             CE0,
    output logic             MISO,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_underrun,
    output logic             busy
);
    localparam int              CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST     = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   FULL     = CW'(WIDTH);
    localparam logic            IDLE_LVL = (CPOL != 0);
    localparam logic [WIDTH-1:0] TX_DEF  = TX_DEFAULT[WIDTH-1:0];

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t                 state;
    logic [CW-1:0]          bit_cnt;
    logic [WIDTH-1:0]       rx_shift;
    logic [WIDTH-1:0]       tx_shift;
    logic [WIDTH-1:0]       hold;
    logic                   word_done;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ce_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   ce_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= {SYNC_STAGES{IDLE_LVL}};
            ce_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= IDLE_LVL;
            ce_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            ce_sync   <= {ce_sync[SYNC_STAGES-2:0], CE0};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            ce_d      <= ce_sync[SYNC_STAGES-1];
        end
    end

    logic sclk_s, ce_s, mosi_s;
    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic ce_fall, ce_rise, sampling, complete;
    logic [WIDTH-1:0] rx_next, tx_next;
    logic tx_head;

    assign sclk_s      = sclk_sync[SYNC_STAGES-1];
    assign ce_s        = ce_sync[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[SYNC_STAGES-1];
    assign lead_edge   = (sclk_s != IDLE_LVL) && (sclk_d == IDLE_LVL);
    assign trail_edge  = (sclk_s == IDLE_LVL) && (sclk_d != IDLE_LVL);
    assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
    assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;
    assign ce_fall     = ce_d && !ce_s;
    assign ce_rise     = !ce_d && ce_s;
    assign sampling    = (state == SHIFT) && sample_edge && (bit_cnt != FULL);
    assign complete    = sampling && (bit_cnt == LAST);

    assign rx_next = (MSB_FIRST != 0) ? {rx_shift[WIDTH-2:0], mosi_s}
                                      : {mosi_s, rx_shift[WIDTH-1:1]};
    assign tx_next = (MSB_FIRST != 0) ? {tx_shift[WIDTH-2:0], 1'b0}
                                      : {1'b0, tx_shift[WIDTH-1:1]};
    assign tx_head = (MSB_FIRST != 0) ? tx_shift[WIDTH-1] : tx_shift[0];
    assign MISO    = busy & tx_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            hold        <= '0;
            word_done   <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_ready    <= 1'b1;
            tx_underrun <= 1'b0;
            busy        <= 1'b0;
        end else begin
            busy        <= !ce_s;
            word_done   <= complete;
            rx_valid    <= word_done;
            tx_underrun <= 1'b0;
            if (word_done) begin
                rx_data <= rx_shift;
            end
            if (tx_valid && tx_ready) begin
                hold     <= tx_data;
                tx_ready <= 1'b0;
            end
            if (sampling) begin
                rx_shift <= rx_next;
                bit_cnt  <= bit_cnt + CW'(1);
            end
            case (state)
                IDLE: begin
                    if (ce_fall) state <= LOAD;
                end
                // tx_ready high here means the buffer is empty; a word accepted
                // this cycle stays in the buffer for the following word.
                LOAD: begin
                    if (tx_ready) begin
                        tx_shift    <= TX_DEF;
                        tx_underrun <= 1'b1;
                    end else begin
                        tx_shift <= hold;
                        tx_ready <= 1'b1;
                    end
                    bit_cnt <= '0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    if (complete && (CPHA != 0)) begin
                        state <= LOAD;
                    end else if (shift_edge && (bit_cnt == FULL)) begin
                        state <= LOAD;
                    end else if (shift_edge && (bit_cnt != '0)) begin
                        tx_shift <= tx_next;
                    end
                end
                default: state <= IDLE;
            endcase
            // Deselect wins over everything, but a word finishing on this very
            // cycle keeps its received bits so rx_data still updates.
            if (ce_rise) begin
                state    <= IDLE;
                bit_cnt  <= '0;
                tx_shift <= '0;
                if (!complete) rx_shift <= '0;
            end
        end
    end
endmodule
